// File: rtl/mult_div_unit_if.sv
// Handshake and data bundle between the control/datapath and the multiply/divide unit.
// The master side issues operations and MTHI/MTLO writes; the slave side owns HI/LO.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_wr;
    logic             lo_wr;
    logic [WIDTH-1:0] wr_data;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_wr, lo_wr, wr_data,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_wr, lo_wr, wr_data,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Multicycle signed/unsigned multiply (shift-add) and divide (restoring) unit owning HI/LO.
// Magnitudes are iterated for WIDTH cycles, then signs are applied in a single FIX cycle.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input logic            clk,
    input logic            reset,
    mult_div_unit_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

    function automatic logic [WIDTH-1:0] cond_neg(input logic signed [WIDTH-1:0] v,
                                                  input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg_wide(input logic signed [2*WIDTH-1:0] v,
                                                         input logic neg);
        return neg ? -v : v;
    endfunction

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             is_div, neg_q, neg_r;
    logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             done_q, dz_q;

    logic             sign_a, sign_b, div_by_zero;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;

    always_comb begin
        sign_a      = bus.a[WIDTH-1] & ~bus.op[0];
        sign_b      = bus.b[WIDTH-1] & ~bus.op[0];
        mag_a       = cond_neg(bus.a, sign_a);
        mag_b       = cond_neg(bus.b, sign_b);
        div_by_zero = bus.op[1] && (bus.b == '0);
        mul_sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        // Partial remainder shifted left with the next dividend bit; a clear MSB of the difference means it fits.
        div_shift   = {acc_hi, acc_lo[WIDTH-1]};
        div_diff    = div_shift - {1'b0, opnd};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start && !div_by_zero) state_nxt = CALC;
            CALC:    if (cnt == LAST) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy     = (state != IDLE);
        bus.done     = done_q;
        bus.div_zero = dz_q;
        bus.hi       = hi_q;
        bus.lo       = lo_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            acc_hi <= '0;
            acc_lo <= '0;
            opnd   <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (div_by_zero) begin
                            done_q <= 1'b1;
                            dz_q   <= 1'b1;
                        end else begin
                            is_div <= bus.op[1];
                            neg_q  <= sign_a ^ sign_b;
                            neg_r  <= sign_a;
                            cnt    <= '0;
                            acc_hi <= '0;
                            acc_lo <= bus.op[1] ? mag_a : mag_b;
                            opnd   <= bus.op[1] ? mag_b : mag_a;
                        end
                    end else begin
                        if (bus.hi_wr) hi_q <= bus.wr_data;
                        if (bus.lo_wr) lo_q <= bus.wr_data;
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (is_div) begin
                        acc_hi <= div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], ~div_diff[WIDTH]};
                    end else begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    done_q <= 1'b1;
                    if (is_div) begin
                        lo_q <= cond_neg(acc_lo, neg_q);
                        hi_q <= cond_neg(acc_hi, neg_r);
                    end else begin
                        {hi_q, lo_q} <= cond_neg_wide({acc_hi, acc_lo}, neg_q);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Parametrised multicycle multiply/divide unit that owns the HI and LO registers of the multicycle CPU datapath. It executes signed and unsigned MULT/DIV over WIDTH-bit operands taken from the A and B registers, holds the results in HI/LO for the register-data mux, and flags division by zero to the control unit so it can vector to the divide-by-zero exception address. It also supports direct MTHI/MTLO writes.

## Interface
- WIDTH, 32, operand width and width of each of HI and LO (≥ 4)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; clears all state
- start  in  1  request a new operation; sampled only while idle
- op  in  2  op[1]: 0 = multiply, 1 = divide; op[0]: 0 = signed, 1 = unsigned
- a  in  WIDTH  multiplicand / dividend
- b  in  WIDTH  multiplier / divisor
- hi_wr  in  1  load HI from wr_data (MTHI)
- lo_wr  in  1  load LO from wr_data (MTLO)
- wr_data  in  WIDTH  data for hi_wr/lo_wr
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse: operation finished (or rejected on divide-by-zero)
- div_zero  out  1  one-cycle pulse, coincident with done, for divide with b == 0
- hi  out  WIDTH  HI register (product upper half / remainder)
- lo  out  WIDTH  LO register (product lower half / quotient)

## Operation
- States: IDLE, CALC, FIX. Reset → IDLE; busy, done, div_zero, hi, lo, counter all 0.
- IDLE, start=1, divide with b == 0: no state change beyond pulse; HI/LO unchanged; done=1 and div_zero=1 for the next cycle; busy stays 0.
- IDLE, start=1, otherwise: capture |a|, |b| (magnitude if signed, raw if unsigned), record result signs, counter=0, busy=1, go to CALC.
- CALC: one iteration per cycle, exactly WIDTH cycles. Multiply: shift-add over a 2·WIDTH accumulator. Divide: restoring, one quotient bit per cycle, WIDTH+1-bit partial remainder. After the WIDTH-th iteration go to FIX.
- FIX: apply signs, write HI/LO, done=1 for one cycle, busy=0, return to IDLE.
- Multiply result: HI:LO = full 2·WIDTH product, two's complement if signed.
- Divide result: LO = quotient truncated toward zero, HI = remainder with sign of dividend (signed); plain unsigned for op[0]=1.
- Signed most-negative ÷ −1: LO = most-negative value (wraps), HI = 0. No overflow flag.
- start while busy: ignored, no queueing. op/a/b changes after capture: no effect.
- hi_wr/lo_wr: honoured only in IDLE without start; ignored while busy; when start=1 in the same cycle, start wins and the write is dropped. hi_wr and lo_wr together load both from wr_data.
- Reset asserted mid-operation: immediate return to IDLE, all outputs 0, partial result discarded.

## Timing
- Capture edge = edge on which start is sampled in IDLE.
- busy high from the capture edge through the FIX edge: WIDTH+1 cycles.
- HI/LO update and done rise on edge WIDTH+1 after the capture edge; a new start is accepted in that same done cycle, with capture on edge WIDTH+2.
- Divide-by-zero: done/div_zero rise on the capture edge itself, high one cycle.
- hi/lo are registered and stable whenever busy=0; intermediate values never visible on hi/lo.
- MTHI/MTLO: new value visible the cycle after the write edge.

## Test plan
- Reset with hi_wr=1, wr_data=0xFFFFFFFF asserted mid-CALC → busy=0, hi=lo=0 immediately; after release, idle and ready.
- Signed mult a=0xFFFFFFFD (−3), b=7 → done 33 edges after capture, hi=0xFFFFFFFF, lo=0xFFFFFFEB; unsigned mult 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- Signed div a=−7 (0xFFFFFFF9), b=2 → lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1); unsigned same operands → lo=0x7FFFFFFC, hi=1.
- Signed div 0x80000000 ÷ 0xFFFFFFFF → lo=0x80000000, hi=0, no div_zero.
- Div with b=0 after hi=0x1234, lo=0x5678 → done and div_zero pulse one cycle after capture, busy never high, hi/lo unchanged.
- start re-asserted during CALC and hi_wr pulsed while busy → both ignored, original result delivered; back-to-back start in done cycle → second op captured and completes correctly; repeat with WIDTH=8 for 0x7F×0x81 signed → hi=0xC0, lo=0xFF.
